// File: rtl/router_fsm_nch.sv
// rtl/router_fsm_nch.sv - N-channel router controller FSM (optional WAIT_EMPTY timeout: ROUTER_WAIT_TIMEOUT_EN)
module router_fsm_nch #(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              fifo_full,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              drop_state,
    output logic              addr_err,
    output logic [ADDR_W-1:0] addr_out,
    output logic              wait_timeout
);

    if (NUM_CH < 2 || NUM_CH > (1 << ADDR_W) || WAIT_TIMEOUT < 2) begin : g_bad_params
        $error("router_fsm_nch: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_DECODE          = 4'd0,
        S_WAIT_EMPTY      = 4'd1,
        S_LOAD_FIRST      = 4'd2,
        S_LOAD_DATA       = 4'd3,
        S_LOAD_PARITY     = 4'd4,
        S_CHECK_PARITY    = 4'd5,
        S_FIFO_FULL       = 4'd6,
        S_LOAD_AFTER_FULL = 4'd7,
        S_DROP            = 4'd8
    } state_t;

    state_t state;
    state_t next_state;
    logic   addr_ok;
    logic   to_hit;
    logic   timeout_take;

    // Per-channel flag lookup that reads 0 for addresses beyond NUM_CH.
    function automatic logic pick(input logic [NUM_CH-1:0] v, input logic [ADDR_W-1:0] a);
        pick = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(a) == i) pick = v[i];
        end
    endfunction

    assign addr_ok = (32'(data_in) < NUM_CH);

`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    assign to_hit = (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        timeout_take = 1'b0;
        case (state)
            S_DECODE: begin
                if (pkt_valid) begin
                    if (!addr_ok)                 next_state = S_DROP;
                    else if (pick(empty, data_in)) next_state = S_LOAD_FIRST;
                    else                          next_state = S_WAIT_EMPTY;
                end
            end
            S_WAIT_EMPTY: begin
                if (pick(empty, addr_out)) begin
                    next_state = S_LOAD_FIRST;
                end else if (to_hit) begin
                    next_state   = S_DROP;
                    timeout_take = 1'b1;
                end
            end
            S_LOAD_FIRST: next_state = S_LOAD_DATA;
            S_LOAD_DATA: begin
                if (fifo_full)       next_state = S_FIFO_FULL;
                else if (!pkt_valid) next_state = S_LOAD_PARITY;
            end
            S_LOAD_PARITY:  next_state = S_CHECK_PARITY;
            S_CHECK_PARITY: next_state = fifo_full ? S_FIFO_FULL : S_DECODE;
            S_FIFO_FULL: begin
                if (!fifo_full) next_state = S_LOAD_AFTER_FULL;
            end
            S_LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = S_DECODE;
                else if (low_pkt_valid) next_state = S_LOAD_PARITY;
                else                    next_state = S_LOAD_DATA;
            end
            S_DROP: begin
                if (!pkt_valid) next_state = S_DECODE;
            end
            default: next_state = S_DECODE;
        endcase
        // Soft reset of the latched channel aborts any in-flight packet.
        if (state != S_DECODE && state != S_DROP && pick(soft_reset, addr_out)) begin
            next_state   = S_DECODE;
            timeout_take = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_DECODE;
            addr_out      <= '0;
            addr_err      <= 1'b0;
            wait_timeout  <= 1'b0;
            busy          <= 1'b0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            full_state    <= 1'b0;
            laf_state     <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            drop_state    <= 1'b0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            state <= next_state;
            if (state == S_DECODE && pkt_valid) addr_out <= data_in;
            addr_err      <= (state == S_DECODE) && pkt_valid && !addr_ok;
            wait_timeout  <= timeout_take;
            busy          <= (next_state == S_LOAD_FIRST)   || (next_state == S_WAIT_EMPTY)   ||
                             (next_state == S_LOAD_PARITY)  || (next_state == S_CHECK_PARITY) ||
                             (next_state == S_FIFO_FULL)    || (next_state == S_LOAD_AFTER_FULL);
            detect_add    <= (next_state == S_DECODE);
            lfd_state     <= (next_state == S_LOAD_FIRST);
            ld_state      <= (next_state == S_LOAD_DATA);
            full_state    <= (next_state == S_FIFO_FULL);
            laf_state     <= (next_state == S_LOAD_AFTER_FULL);
            write_enb_reg <= (next_state == S_LOAD_DATA) || (next_state == S_LOAD_PARITY) ||
                             (next_state == S_LOAD_AFTER_FULL);
            rst_int_reg   <= (next_state == S_CHECK_PARITY);
            drop_state    <= (next_state == S_DROP);
`ifdef ROUTER_WAIT_TIMEOUT_EN
            // Held at zero outside WAIT_EMPTY, so every entry starts a fresh count.
            if (state == S_WAIT_EMPTY) wait_cnt <= wait_cnt + 1'b1;
            else                       wait_cnt <= '0;
`endif
        end
    end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised N-channel router controller FSM. It sits between the router input register block and the per-channel synchroniser/FIFO group. It decodes the header address and sequences header, payload and parity loading, full-stall recovery and per-channel soft reset. New relative to the 3-channel controller: generic channel count, latched-address soft-reset qualification, and an invalid-address drop path.

Parameters:
NUM_CH, 3, number of output channels (2..2**ADDR_W)
ADDR_W, 2, width of header address field
WAIT_TIMEOUT, 64, max cycles in WAIT_EMPTY (used only with optional feature; >=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pkt_valid  in  1  packet byte valid from source
data_in  in  ADDR_W  header address bits (data_in[ADDR_W-1:0] of header byte)
empty  in  NUM_CH  per-channel FIFO empty
soft_reset  in  NUM_CH  per-channel soft reset from synchroniser
fifo_full  in  1  full flag of currently selected FIFO
parity_done  in  1  parity byte captured (from register block)
low_pkt_valid  in  1  pkt_valid fell while stalled (from register block)
busy  out  1  stall source
detect_add  out  1  in DECODE
lfd_state  out  1  in LOAD_FIRST
ld_state  out  1  in LOAD_DATA
full_state  out  1  in FIFO_FULL
laf_state  out  1  in LOAD_AFTER_FULL
write_enb_reg  out  1  register block may write FIFO
rst_int_reg  out  1  in CHECK_PARITY
drop_state  out  1  in DROP
addr_err  out  1  one-cycle pulse, invalid header address
addr_out  out  ADDR_W  latched channel address
wait_timeout  out  1  one-cycle pulse (optional feature only; else tied 0)

Behaviour:
- Async reset: state=DECODE, addr_out=0, addr_err=0, wait_timeout=0. Outputs are pure state decodes, so detect_add=1 and all others are 0 in reset.
- Address valid iff data_in < NUM_CH. In DECODE, pkt_valid=1 latches addr_out<=data_in on the next edge, valid or not.
- DECODE, pkt_valid & valid & empty[data_in]: -> LOAD_FIRST.
- DECODE, pkt_valid & valid & !empty[data_in]: -> WAIT_EMPTY.
- DECODE, pkt_valid & !valid: -> DROP; addr_err=1 during the first DROP cycle only (registered).
- DECODE, otherwise: stay.
- WAIT_EMPTY: empty[addr_out] -> LOAD_FIRST, else stay.
- LOAD_FIRST: -> LOAD_DATA unconditionally.
- LOAD_DATA: fifo_full -> FIFO_FULL; else !pkt_valid -> LOAD_PARITY; else stay. fifo_full has priority.
- LOAD_PARITY: -> CHECK_PARITY.
- CHECK_PARITY: fifo_full -> FIFO_FULL, else -> DECODE.
- FIFO_FULL: !fifo_full -> LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL: parity_done -> DECODE; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
- DROP: discard bytes, no writes, busy=0; !pkt_valid -> DECODE.
- busy=1 in LOAD_FIRST, WAIT_EMPTY, LOAD_PARITY, CHECK_PARITY, FIFO_FULL, LOAD_AFTER_FULL.
- write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
- Soft reset: if soft_reset[addr_out]=1 in any state other than DECODE or DROP, next state=DECODE. This overrides all transitions. Soft resets on other channels are ignored.
- Illegal state encoding: -> DECODE next cycle.
- Reset mid-packet: immediate DECODE; the partial packet is not resumed.

Optional Feature:
ROUTER_WAIT_TIMEOUT_EN:
- Defined: a counter clears on WAIT_EMPTY entry and increments each WAIT_EMPTY cycle. If empty[addr_out] is still 0 after WAIT_TIMEOUT cycles, -> DROP and wait_timeout pulses 1 cycle; addr_err is not asserted. empty[addr_out]=1 on the same edge wins and goes to LOAD_FIRST.
- Undefined: no counter, WAIT_EMPTY waits indefinitely, wait_timeout tied 0.

Test Plan:
1. NUM_CH=3, empty=3'b111, pkt_valid=1, data_in=1, 4 payload bytes, then pkt_valid=0 -> states DECODE,LOAD_FIRST,LOAD_DATA x4,LOAD_PARITY,CHECK_PARITY,DECODE; addr_out=1; write_enb_reg high for 5 cycles.
2. data_in=2, empty[2]=0 for 5 cycles then 1 -> busy=1 in WAIT_EMPTY for 5 cycles, then LOAD_FIRST.
3. In LOAD_DATA assert fifo_full for 3 cycles, low_pkt_valid=1, parity_done=0 -> FIFO_FULL x3, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY, DECODE.
4. NUM_CH=3, data_in=3 with pkt_valid held 4 cycles -> DROP, addr_err single pulse, busy=0, write_enb_reg=0 throughout, then DECODE.
5. Packet on channel 0 in LOAD_DATA: soft_reset=3'b010 -> no effect; soft_reset=3'b001 -> DECODE next cycle.
6. With ROUTER_WAIT_TIMEOUT_EN, WAIT_TIMEOUT=8, empty[addr_out] held 0 -> DROP after 8 WAIT_EMPTY cycles, wait_timeout pulses once; assert reset mid-DROP -> detect_add=1 immediately.
